imem_responder: RTL and testbench
=================================

// Module: imem_responder
// PURPOSE
//  Instruction-memory responder: the memory-side end of the fetch request interface (request/we_re/mask/address).
//  Accepts one request at a time, inserts WAIT_STATES cycles of latency, then returns a word with a 1-cycle valid.
//  Writes are byte-masked and used for program loading and self-modifying tests.
//  Sits between the fetch stage and the on-chip instruction store.
// PARAMETERS
//  INSTRUCTION  32     data word width (bits); must be 32
//  ADDRESS      32     byte-address width
//  DEPTH        1024   storage depth in words; power of two
//  WAIT_STATES  1      extra latency cycles between accept and response; 0..15
// PORTS
//  clk          in   1            clock; all logic on rising edge
//  rst          in   1            synchronous active-high reset
//  request      in   1            request strobe from the fetch side
//  we_re        in   1            1 = write, 0 = read
//  mask         in   4            byte enables for writes; bit i -> wdata[8i+7:8i]
//  address      in   ADDRESS      byte address
//  wdata        in   INSTRUCTION  write data
//  ready        out  1            high when a request is accepted this cycle
//  valid        out  1            one-cycle response strobe
//  instruction  out  INSTRUCTION  read data; held until the next response
//  err          out  1            access error, qualified by valid (IMEM_ERR_EN only; else tied 0)
// BEHAVIOUR
//  - Reset: state=IDLE, ready=1, valid=0, instruction=0, err=0, wait counter=0.
//    Storage contents are not reset.
//  - FSM IDLE -> WAIT -> RESP -> IDLE.
//    - IDLE: ready=1. On request=1, latch address, we_re, mask and wdata.
//      - If WAIT_STATES=0, go to RESP; otherwise go to WAIT with counter=WAIT_STATES-1.
//    - WAIT: ready=0. Decrement the counter; at 0, go to RESP.
//    - RESP: ready=0, valid=1 for exactly one cycle, then go to IDLE.
//  - Latency: accept at edge N -> valid high in cycle N+1+WAIT_STATES.
//    Max throughput is one transaction per WAIT_STATES+2 cycles.
//  - Request inputs are ignored while ready=0. Nothing is queued.
//    A requester that holds request high is re-accepted in the first IDLE cycle.
//  - Word index = address[$clog2(DEPTH)+1:2].
//    address[1:0] and the upper bits are ignored, so the address wraps modulo DEPTH*4.
//  - Read: instruction <= mem[index] (full word) on the edge that enters RESP. mask is ignored.
//  - Write: for each mask bit set, update the matching byte on the edge that enters RESP.
//    - instruction <= the post-write word.
//    - mask=4'b0000 writes nothing but still produces a valid response.
//  - Reset mid-transaction (WAIT or RESP): the transaction is dropped.
//    No write is committed if RESP has not been entered, and no valid is produced.
//  - instruction holds its last value when valid=0.
// CONFIGURATION
//  Macro IMEM_ERR_EN:
//  - Defined: err=1 with valid if address[1:0]!=0 or address>=DEPTH*4.
//    - Such a write is suppressed.
//    - Such a read returns 32'h0000_0013 (NOP).
//  - Undefined: err is constant 0 and the wrap/ignore rules above apply.
// STRUCTURE
//  - Package imem_pkg holds:
//    - typedef enum logic [1:0] {IDLE, WAIT, RESP} imem_state_t
//    - localparam NOP_INSTR = 32'h0000_0013
//    - localparam WORD_BYTES = 4
//  - Sub-module imem_bank: DEPTH x 32 array with a synchronous byte-enable write and a synchronous read port.
//    The FSM, wait counter and error check stay in imem_responder.
// TESTING
//  - WAIT_STATES=1. Preload mem[4]=32'hDEADBEEF; read address 0x10.
//    -> ready falls the cycle after accept; valid on the 2nd cycle after accept; instruction=32'hDEADBEEF; err=0.
//  - Write 0x10, wdata=32'h11223344, mask=4'b0101, over 32'hDEADBEEF.
//    -> response 32'hDE22BE44; a following read returns the same.
//  - request held high continuously, WAIT_STATES=0.
//    -> valid every 2nd cycle; ready pattern 1,0,1,0.
//  - Assert rst in WAIT during a write of 32'hFFFFFFFF to 0x20.
//    -> no valid; mem[8] unchanged; instruction=0; ready=1 after reset.
//  - DEPTH=1024, read 0x1010 without IMEM_ERR_EN.
//    -> returns mem[4] (wrap), err=0.
//  - With IMEM_ERR_EN, read 0x12.
//    -> err=1, instruction=32'h00000013.
//  - With IMEM_ERR_EN, write to 0x1000.
//    -> err=1 and storage unchanged.

Source files
------------

// File: rtl/imem_pkg.sv
// Shared types and constants for the instruction-memory responder.
package imem_pkg;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} imem_state_t;

  localparam logic [31:0] NOP_INSTR  = 32'h0000_0013;
  localparam int          WORD_BYTES = 4;

endpackage

// File: rtl/imem_bank.sv
// Instruction storage: DEPTH x 32 words with a byte-enable write and a
// registered read port. On an enabled access the read register captures the
// post-write word, so a write reports the merged result.
module imem_bank
  import imem_pkg::*;
#(
  parameter int DEPTH = 1024,
  parameter int IDX_W = $clog2(DEPTH)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en_i,
  input  logic                    we_i,
  input  logic [WORD_BYTES-1:0]   mask_i,
  input  logic [IDX_W-1:0]        idx_i,
  input  logic [31:0]             wdata_i,
  output logic [31:0]             rdata_o
);

  logic [31:0] mem_q [DEPTH];
  logic [31:0] rdata_q;
  logic [31:0] merged;

  // Word as it will look after this access (current word with enabled bytes replaced).
  always_comb begin
    merged = mem_q[idx_i];
    if (we_i) begin
      for (int b = 0; b < WORD_BYTES; b++) begin
        if (mask_i[b]) merged[8*b +: 8] = wdata_i[8*b +: 8];
      end
    end
  end

  // Byte-enable write; contents are never reset.
  always_ff @(posedge clk) begin
    if (en_i && we_i) begin
      for (int b = 0; b < WORD_BYTES; b++) begin
        if (mask_i[b]) mem_q[idx_i][8*b +: 8] <= wdata_i[8*b +: 8];
      end
    end
  end

  // Read register: cleared by reset, otherwise holds until the next access.
  always_ff @(posedge clk) begin
    if (rst)       rdata_q <= '0;
    else if (en_i) rdata_q <= merged;
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/imem_responder.sv
// Memory-side end of the instruction fetch interface. Accepts one request at
// a time, waits WAIT_STATES cycles, then presents a one-cycle valid response.
// Optional feature: define IMEM_ERR_EN to flag misaligned/out-of-range
// accesses (write suppressed, read returns NOP); otherwise err is tied 0 and
// addresses wrap modulo DEPTH*4.
module imem_responder
  import imem_pkg::*;
#(
  parameter int INSTRUCTION = 32,
  parameter int ADDRESS     = 32,
  parameter int DEPTH       = 1024,
  parameter int WAIT_STATES = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   request,
  input  logic                   we_re,
  input  logic [WORD_BYTES-1:0]  mask,
  input  logic [ADDRESS-1:0]     address,
  input  logic [INSTRUCTION-1:0] wdata,
  output logic                   ready,
  output logic                   valid,
  output logic [INSTRUCTION-1:0] instruction,
  output logic                   err
);

  localparam int IDX_W = $clog2(DEPTH);

  imem_state_t state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        err_q;
  logic        fire;

  logic [ADDRESS-1:0]     addr_q;
  logic                   we_q;
  logic [WORD_BYTES-1:0]  mask_q;
  logic [INSTRUCTION-1:0] wdata_q;

  logic [ADDRESS-1:0]     acc_addr;
  logic                   acc_we;
  logic [WORD_BYTES-1:0]  acc_mask;
  logic [INSTRUCTION-1:0] acc_wdata;
  logic                   acc_err;
  logic                   addr_unused;
  logic [31:0]            bank_rdata;

  // With zero wait states the memory is accessed on the accept edge itself,
  // before the latches are loaded, so the live inputs must be used in IDLE.
  assign acc_addr  = (state_q == IDLE) ? address : addr_q;
  assign acc_we    = (state_q == IDLE) ? we_re   : we_q;
  assign acc_mask  = (state_q == IDLE) ? mask    : mask_q;
  assign acc_wdata = (state_q == IDLE) ? wdata   : wdata_q;

`ifdef IMEM_ERR_EN
  assign acc_err = (acc_addr[1:0] != 2'b00) || ((acc_addr >> (IDX_W + 2)) != '0);
`else
  assign acc_err = 1'b0;
`endif
  assign addr_unused = ^{acc_addr[1:0], acc_addr[ADDRESS-1:IDX_W+2]};

  // Next-state logic; fire marks the edge that enters RESP (memory access edge).
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    fire    = 1'b0;
    case (state_q)
      IDLE: begin
        if (request) begin
          if (WAIT_STATES == 0) begin
            state_d = RESP;
            fire    = 1'b1;
          end else begin
            state_d = WAIT;
            cnt_d   = 4'(WAIT_STATES - 1);
          end
        end
      end
      WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d = RESP;
          fire    = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Control registers; reset drops any transaction in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (fire) err_q <= acc_err;
    end
  end

  // Request latch, loaded only when a request is accepted.
  always_ff @(posedge clk) begin
    if (state_q == IDLE && request) begin
      addr_q  <= address;
      we_q    <= we_re;
      mask_q  <= mask;
      wdata_q <= wdata;
    end
  end

  imem_bank #(.DEPTH(DEPTH)) u_bank (
    .clk     (clk),
    .rst     (rst),
    .en_i    (fire && !rst),
    .we_i    (acc_we && !acc_err),
    .mask_i  (acc_mask),
    .idx_i   (acc_addr[IDX_W+1:2]),
    .wdata_i (acc_wdata),
    .rdata_o (bank_rdata)
  );

  assign ready       = (state_q == IDLE);
  assign valid       = (state_q == RESP);
  assign err         = valid && err_q;
  assign instruction = err_q ? NOP_INSTR : bank_rdata;

endmodule

// File: tb/tb_imem_responder.sv
// Randomized scoreboard bench for imem_responder (WAIT_STATES=1 main instance,
// plus a WAIT_STATES=0 instance for back-to-back held requests).
module tb_imem_responder;

  localparam int DEPTH = 1024;
  localparam int WS    = 1;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // Main instance (WAIT_STATES=1)
  logic        req1 = 1'b0, we1 = 1'b0;
  logic [3:0]  mask1 = 4'h0;
  logic [31:0] addr1 = '0, wdata1 = '0;
  logic        ready1, valid1, err1;
  logic [31:0] instruction1;

  // Zero-wait instance
  logic        req0 = 1'b0, we0 = 1'b0;
  logic [3:0]  mask0 = 4'h0;
  logic [31:0] addr0 = '0, wdata0 = '0;
  logic        ready0, valid0, err0;
  logic [31:0] instruction0;

  imem_responder #(.INSTRUCTION(32), .ADDRESS(32), .DEPTH(DEPTH), .WAIT_STATES(WS)) dut1 (
    .clk(clk), .rst(rst), .request(req1), .we_re(we1), .mask(mask1), .address(addr1),
    .wdata(wdata1), .ready(ready1), .valid(valid1), .instruction(instruction1), .err(err1));

  imem_responder #(.INSTRUCTION(32), .ADDRESS(32), .DEPTH(DEPTH), .WAIT_STATES(0)) dut0 (
    .clk(clk), .rst(rst), .request(req0), .we_re(we0), .mask(mask0), .address(addr0),
    .wdata(wdata0), .ready(ready0), .valid(valid0), .instruction(instruction0), .err(err0));

  typedef struct {
    logic [31:0] instr;
    logic        err;
    bit          chk_instr;
    int          cyc;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] model_mem [DEPTH];
  logic [31:0] last_instr = '0;
  int          cyc = 0;
  int          checks = 0;
  int          failures = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Reference: word-addressed array, byte merge, error rules from the address.
  task automatic model_push(input bit we, input logic [3:0] m, input logic [31:0] a,
                            input logic [31:0] d, input int acc_cyc);
    exp_t e;
    int   idx;
    bit   bad;
    bad = 1'b0;
`ifdef IMEM_ERR_EN
    bad = (a % 4 != 0) || (a >= DEPTH * 4);
`endif
    idx = (a / 4) % DEPTH;
    if (we && !bad) begin
      for (int b = 0; b < 4; b++)
        if (m[b]) model_mem[idx][8*b +: 8] = d[8*b +: 8];
    end
    e.instr     = bad ? NOP : model_mem[idx];
    e.err       = bad;
    e.chk_instr = !(bad && we);
    e.cyc       = acc_cyc + 1 + WS;
    sb.push_back(e);
  endtask

  task automatic txn(input bit we, input logic [3:0] m, input logic [31:0] a, input logic [31:0] d);
    int n;
    @(negedge clk);
    req1 = 1'b1; we1 = we; mask1 = m; addr1 = a; wdata1 = d;
    n = 0;
    while (!ready1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!ready1) begin
      check("accept_timeout", 32'(ready1), 32'd1);
      req1 = 1'b0;
    end else begin
      model_push(we, m, a, d, cyc);
      @(posedge clk);
      #1;
      req1 = 1'b0;
      check("ready_drop", 32'(ready1), 32'd0);
      n = 0;
      while (sb.size() != 0 && n < 40) begin
        @(negedge clk);
        n++;
      end
      if (sb.size() != 0) begin
        check("resp_timeout", 32'(sb.size()), 32'd0);
        sb.delete();
      end
    end
  endtask

  // Monitor: pop and compare on every response; otherwise instruction must hold.
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      last_instr = '0;
    end else if (valid1) begin
      if (sb.size() == 0) begin
        check("unexpected_valid", 32'(valid1), 32'd0);
      end else begin
        e = sb.pop_front();
        check("resp_latency", 32'(cyc), 32'(e.cyc));
        check("resp_err", 32'(err1), 32'(e.err));
        if (e.chk_instr) begin
          check("resp_instr", instruction1, e.instr);
          last_instr = e.instr;
        end else begin
          last_instr = instruction1;
        end
      end
    end else begin
      check("hold_instr", instruction1, last_instr);
      check("err_idle", 32'(err1), 32'd0);
    end
  end

  initial begin
    logic [31:0] a, d;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_ready", 32'(ready1), 32'd1);
    check("rst_valid", 32'(valid1), 32'd0);
    check("rst_instr", instruction1, 32'h0);
    check("rst_err", 32'(err1), 32'd0);
    check("rst_ready0", 32'(ready0), 32'd1);

    // Fill the low words so every later read has a known value.
    for (int i = 0; i < 16; i++) txn(1'b1, 4'hF, 32'(i * 4), $urandom);

    // Directed cases
    txn(1'b1, 4'hF, 32'h10, 32'hDEADBEEF);
    txn(1'b0, 4'h0, 32'h10, 32'h0);
    check("dir_deadbeef", model_mem[4], 32'hDEADBEEF);
    txn(1'b1, 4'b0101, 32'h10, 32'h11223344);
    check("dir_merge", model_mem[4], 32'hDE22BE44);
    txn(1'b0, 4'h0, 32'h10, 32'h0);
    txn(1'b0, 4'h0, 32'h1010, 32'h0);
    txn(1'b1, 4'h0, 32'h14, 32'hFFFFFFFF);
    txn(1'b0, 4'h0, 32'h14, 32'h0);
    txn(1'b0, 4'h0, 32'h12, 32'h0);
    txn(1'b1, 4'hF, 32'h1000, 32'hCAFEF00D);
    txn(1'b0, 4'h0, 32'h0, 32'h0);

    // Reset while a write is waiting: nothing committed, nothing returned.
    @(negedge clk);
    req1 = 1'b1; we1 = 1'b1; mask1 = 4'hF; addr1 = 32'h20; wdata1 = 32'hFFFFFFFF;
    @(posedge clk);
    #1;
    req1 = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst_ready", 32'(ready1), 32'd1);
    check("midrst_valid", 32'(valid1), 32'd0);
    check("midrst_instr", instruction1, 32'h0);
    txn(1'b0, 4'h0, 32'h20, 32'h0);

    // Randomized traffic
    for (int t = 0; t < 60; t++) begin
      a = 32'($urandom_range(0, 15) * 4);
      if ($urandom_range(0, 3) == 0) a = a + 32'($urandom_range(1, 3) << 12);
      if ($urandom_range(0, 7) == 0) a = a + 32'($urandom_range(1, 3));
      d = $urandom;
      txn(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), a, d);
    end

    // Zero-wait instance with request held high: one transaction every 2 cycles.
    @(negedge clk);
    req0 = 1'b1; we0 = 1'b1; mask0 = 4'hF; addr0 = 32'h0; wdata0 = 32'h11223344;
    for (int k = 0; k < 8; k++) begin
      check("held_ready", 32'(ready0), 32'((k % 2) == 0));
      check("held_valid", 32'(valid0), 32'((k % 2) == 1));
      if ((k % 2) == 1) check("held_instr", instruction0, 32'h11223344);
      @(negedge clk);
    end
    req0 = 1'b0;
    repeat (3) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
